// File: rtl/gba_video_timing.sv
// GBA-style LCD timing generator: dot divider, h/v counters, blanking/sync flags,
// LYC compare and single-cycle interrupt request pulses on flag rising edges.
module gba_video_timing #(
  parameter int H_ACTIVE = 240,
  parameter int H_TOTAL  = 308,
  parameter int V_ACTIVE = 160,
  parameter int V_TOTAL  = 228,
  parameter int CLK_DIV  = 4,
  parameter int HS_START = 280,
  parameter int HS_END   = 290,
  parameter int VS_START = 160,
  parameter int VS_END   = 166,
  parameter int FW       = 16
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       enable,
  input  logic [$clog2(V_TOTAL)-1:0] lyc,
  input  logic [2:0]                 irq_en,
  output logic [$clog2(H_TOTAL)-1:0] hcount,
  output logic [$clog2(V_TOTAL)-1:0] vcount,
  output logic                       hblank,
  output logic                       vblank,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       vcount_match,
  output logic                       vblank_irq,
  output logic                       hblank_irq,
  output logic                       vcount_irq,
  output logic                       dot_tick,
  output logic [FW-1:0]              frame_count
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

  logic [DW-1:0] div_r;
  logic [DW-1:0] div_nxt_s;
  logic [HW-1:0] h_nxt_s;
  logic [VW-1:0] v_nxt_s;
  logic [FW-1:0] frame_nxt_s;
  logic          hblank_nxt_s;
  logic          vblank_nxt_s;
  logic          hsync_nxt_s;
  logic          vsync_nxt_s;
  logic          match_nxt_s;

  assign dot_tick = enable && (div_r == DIV_LAST);

  // Next-state counters; with enable low every next value equals the current one
  always_comb begin
    div_nxt_s   = div_r;
    h_nxt_s     = hcount;
    v_nxt_s     = vcount;
    frame_nxt_s = frame_count;
    if (enable) begin
      if (div_r == DIV_LAST) begin
        div_nxt_s = {DW{1'b0}};
      end else begin
        div_nxt_s = div_r + DW'(1);
      end
    end else begin
      div_nxt_s = div_r;
    end
    if (dot_tick) begin
      if (hcount == H_LAST) begin
        h_nxt_s = {HW{1'b0}};
        if (vcount == V_LAST) begin
          v_nxt_s     = {VW{1'b0}};
          frame_nxt_s = frame_count + FW'(1);
        end else begin
          v_nxt_s = vcount + VW'(1);
        end
      end else begin
        h_nxt_s = hcount + HW'(1);
      end
    end else begin
      h_nxt_s = hcount;
    end
  end

  // Flags decoded from the next counts so the registered flag tracks the registered count
  always_comb begin
    hblank_nxt_s = (int'(h_nxt_s) >= H_ACTIVE);
    vblank_nxt_s = (int'(v_nxt_s) >= V_ACTIVE);
    hsync_nxt_s  = (int'(h_nxt_s) >= HS_START) && (int'(h_nxt_s) < HS_END);
    vsync_nxt_s  = (int'(v_nxt_s) >= VS_START) && (int'(v_nxt_s) < VS_END);
    match_nxt_s  = (v_nxt_s == lyc);
  end

  // State registers; irq pulses fire on the edge where the flag goes 0->1
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      div_r        <= {DW{1'b0}};
      hcount       <= {HW{1'b0}};
      vcount       <= {VW{1'b0}};
      frame_count  <= {FW{1'b0}};
      hblank       <= 1'b0;
      vblank       <= 1'b0;
      hsync        <= 1'b0;
      vsync        <= 1'b0;
      vcount_match <= 1'b0;
      hblank_irq   <= 1'b0;
      vblank_irq   <= 1'b0;
      vcount_irq   <= 1'b0;
    end else begin
      div_r        <= div_nxt_s;
      hcount       <= h_nxt_s;
      vcount       <= v_nxt_s;
      frame_count  <= frame_nxt_s;
      hblank       <= hblank_nxt_s;
      vblank       <= vblank_nxt_s;
      hsync        <= hsync_nxt_s;
      vsync        <= vsync_nxt_s;
      vcount_match <= match_nxt_s;
      hblank_irq   <= irq_en[1] & hblank_nxt_s & ~hblank;
      vblank_irq   <= irq_en[0] & vblank_nxt_s & ~vblank;
      vcount_irq   <= irq_en[2] & match_nxt_s & ~vcount_match;
    end
  end

endmodule

// File: tb/tb_gba_video_timing.sv
// Scoreboard bench for gba_video_timing: horizontal timing at defaults, short 12-line
// frame so full-frame, vblank and frame-wrap behaviour fit in a short run.
module tb_gba_video_timing;

  localparam int VA  = 8;
  localparam int VT  = 12;
  localparam int VSS = 8;
  localparam int VSE = 10;
  localparam int LW  = $clog2(VT);
  localparam int HW  = $clog2(308);
  localparam int FRAME = 1232 * VT;

  localparam int S_H = 0, S_V = 1, S_HB = 2, S_VB = 3, S_HS = 4, S_VS = 5, S_M = 6;
  localparam int S_VBI = 7, S_HBI = 8, S_VCI = 9, S_DT = 10, S_FC = 11, S_DTL = 12;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          enable;
  logic [LW-1:0] lyc;
  logic [2:0]    irq_en;
  logic [HW-1:0] hcount;
  logic [LW-1:0] vcount;
  logic          hblank, vblank, hsync, vsync, vcount_match;
  logic          vblank_irq, hblank_irq, vcount_irq, dot_tick;
  logic [15:0]   frame_count;

  gba_video_timing #(
    .V_ACTIVE(VA), .V_TOTAL(VT), .VS_START(VSS), .VS_END(VSE)
  ) dut (
    .clk(clk), .rst_b(rst_b), .enable(enable), .lyc(lyc), .irq_en(irq_en),
    .hcount(hcount), .vcount(vcount), .hblank(hblank), .vblank(vblank),
    .hsync(hsync), .vsync(vsync), .vcount_match(vcount_match),
    .vblank_irq(vblank_irq), .hblank_irq(hblank_irq), .vcount_irq(vcount_irq),
    .dot_tick(dot_tick), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    at;
    int    sel;
    int    val;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   edges = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   base;
  logic dt_pre = 1'b0;

  // dot_tick as seen just before the following rising edge
  always @(negedge clk) dt_pre <= dot_tick;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_H:     return 32'(hcount);
      S_V:     return 32'(vcount);
      S_HB:    return 32'(hblank);
      S_VB:    return 32'(vblank);
      S_HS:    return 32'(hsync);
      S_VS:    return 32'(vsync);
      S_M:     return 32'(vcount_match);
      S_VBI:   return 32'(vblank_irq);
      S_HBI:   return 32'(hblank_irq);
      S_VCI:   return 32'(vcount_irq);
      S_DT:    return 32'(dt_pre);
      S_FC:    return 32'(frame_count);
      S_DTL:   return 32'(dot_tick);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic cmp(input string tag, input logic [31:0] o, input int e);
    vectors++;
    assert (o === 32'(e)) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic push(input int at, input int sel, input int val, input string tag);
    exp_t x;
    x.at = at; x.sel = sel; x.val = val; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic check_due();
    exp_t keep[$];
    foreach (sb[i]) begin
      if (sb[i].at == edges) cmp($sformatf("%s@%0d", sb[i].tag, edges), obs(sb[i].sel), sb[i].val);
      else keep.push_back(sb[i]);
    end
    sb = keep;
  endtask

  task automatic step();
    @(posedge clk);
    edges++;
    #1;
    check_due();
  endtask

  task automatic wait_for(input int sel, input int val);
    int n = 0;
    while (obs(sel) !== 32'(val) && n < 20000) begin
      step();
      n++;
    end
    if (n >= 20000) cmp($sformatf("wait_sel%0d", sel), obs(sel), val);
  endtask

  task automatic check_all_zero(input string tag);
    for (int s = 0; s <= S_DTL; s++) begin
      if (s != S_DT) cmp($sformatf("%s_sel%0d", tag, s), obs(s), 0);
    end
  endtask

  task automatic push_line0(input int b);
    push(b + 1,    S_VCI, 0,   "no_pulse_release");
    push(b + 1,    S_M,   0,   "match_release");
    push(b + 3,    S_H,   0,   "hcount_e3");
    push(b + 3,    S_DT,  0,   "dot_e3");
    push(b + 4,    S_H,   1,   "hcount_e4");
    push(b + 4,    S_DT,  1,   "dot_e4");
    push(b + 5,    S_DT,  0,   "dot_e5");
    push(b + 959,  S_HB,  0,   "hblank_e959");
    push(b + 960,  S_HB,  1,   "hblank_e960");
    push(b + 960,  S_HBI, 1,   "hbirq_e960");
    push(b + 960,  S_H,   240, "hcount_e960");
    push(b + 961,  S_HBI, 0,   "hbirq_e961");
    push(b + 1232, S_H,   0,   "hcount_e1232");
    push(b + 1232, S_V,   1,   "vcount_e1232");
    push(b + 1232, S_HB,  0,   "hblank_e1232");
  endtask

  initial begin
    rst_b  = 1'b0;
    enable = 1'b1;
    lyc    = LW'(3);
    irq_en = 3'b111;
    #12;
    check_all_zero("reset");

    // first frame from release
    @(negedge clk);
    rst_b = 1'b1;
    base  = edges;
    push_line0(base);
    push(base + 1119, S_HS, 0, "hsync_pre");
    push(base + 1120, S_HS, 1, "hsync_rise");
    push(base + 1160, S_HS, 0, "hsync_fall");
    push(base + 3695, S_M,   0, "match_e3695");
    push(base + 3696, S_V,   3, "vcount_e3696");
    push(base + 3696, S_M,   1, "match_e3696");
    push(base + 3696, S_VCI, 1, "vcirq_e3696");
    push(base + 3697, S_VCI, 0, "vcirq_e3697");
    push(base + 4928, S_M,   0, "match_fall");
    push(base + 4928, S_VCI, 0, "vcirq_fall");
    push(base + 1232 * VA - 1, S_VB,  0, "vblank_pre");
    push(base + 1232 * VA,     S_VB,  1, "vblank_rise");
    push(base + 1232 * VA,     S_VBI, 1, "vbirq_rise");
    push(base + 1232 * VA,     S_VS,  1, "vsync_rise");
    push(base + 1232 * VA + 1, S_VBI, 0, "vbirq_end");
    push(base + 1232 * VSE,    S_VS,  0, "vsync_fall");
    push(base + FRAME - 1, S_FC, 0, "frame_pre");
    push(base + FRAME,     S_FC, 1, "frame_wrap");
    push(base + FRAME,     S_V,  0, "vcount_wrap");
    push(base + FRAME,     S_VB, 0, "vblank_wrap");
    while (edges < base + FRAME + 6) step();

    // enable freeze at hcount=100
    wait_for(S_H, 100);
    enable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      push(edges + 1, S_H,   100, "hold_h");
      push(edges + 1, S_DT,  0,   "hold_dot");
      push(edges + 1, S_HB,  0,   "hold_hb");
      push(edges + 1, S_HBI, 0,   "hold_hbirq");
      push(edges + 1, S_VCI, 0,   "hold_vcirq");
      step();
    end
    enable = 1'b1;
    push(edges + 559, S_HB,  0,   "resume_hb_pre");
    push(edges + 560, S_HB,  1,   "resume_hb");
    push(edges + 560, S_HBI, 1,   "resume_hbirq");
    push(edges + 560, S_H,   240, "resume_h");
    for (int i = 0; i < 562; i++) step();

    // lyc write while on line 10, with and without the irq enable
    wait_for(S_V, 10);
    lyc = LW'(10);
    push(edges + 1, S_M,   1, "lyc_match");
    push(edges + 1, S_VCI, 1, "lyc_irq");
    push(edges + 2, S_VCI, 0, "lyc_irq_end");
    step(); step();
    irq_en = 3'b011;
    lyc    = LW'(3);
    push(edges + 1, S_M, 0, "lyc_off");
    step();
    lyc = LW'(10);
    push(edges + 1, S_M,   1, "lyc_match_dis");
    push(edges + 1, S_VCI, 0, "lyc_irq_dis");
    step();
    irq_en = 3'b111;
    push(edges + 1, S_VCI, 0, "no_retro");
    push(edges + 1, S_M,   1, "match_kept");
    step();

    // vblank entry coinciding with lyc match
    lyc = LW'(VA);
    wait_for(S_V, VA - 1);
    push(edges + 1231, S_VB,  0, "sim_vb_pre");
    push(edges + 1232, S_VB,  1, "sim_vb");
    push(edges + 1232, S_VBI, 1, "sim_vbirq");
    push(edges + 1232, S_VCI, 1, "sim_vcirq");
    push(edges + 1232, S_M,   1, "sim_match");
    push(edges + 1233, S_VBI, 0, "sim_vbirq_end");
    push(edges + 1233, S_VCI, 0, "sim_vcirq_end");
    for (int i = 0; i < 1234; i++) step();

    // asynchronous reset mid-frame, then line-0 timing again
    wait_for(S_V, 9);
    wait_for(S_H, 200);
    cmp("pre_rst_vblank", obs(S_VB), 1);
    cmp("pre_rst_vsync", obs(S_VS), 1);
    rst_b = 1'b0;
    lyc   = LW'(3);
    #1;
    check_all_zero("rst_async");
    step();
    check_all_zero("rst_edge");
    @(negedge clk);
    rst_b = 1'b1;
    base  = edges;
    push_line0(base);
    for (int i = 0; i < 1236; i++) step();

    // reset with lyc=0 raises the match one cycle after release
    rst_b = 1'b0;
    lyc   = LW'(0);
    step(); step();
    @(negedge clk);
    rst_b = 1'b1;
    base  = edges;
    push(base + 1, S_M,   1, "lyc0_match");
    push(base + 1, S_VCI, 1, "lyc0_irq");
    push(base + 2, S_VCI, 0, "lyc0_irq_end");
    for (int i = 0; i < 3; i++) step();

    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gba_video_timing.md
GBA_VIDEO_TIMING -- requirements
Module: gba_video_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 240: visible dots per line.
REQ-002 SHALL have parameter H_TOTAL, default 308: dots per line, including blank.
REQ-003 SHALL have parameter V_ACTIVE, default 160: visible lines per frame.
REQ-004 SHALL have parameter V_TOTAL, default 228: lines per frame, including blank.
REQ-005 SHALL have parameter CLK_DIV, default 4: clk cycles per dot, >=1.
REQ-006 SHALL have parameters HS_START 280, HS_END 290, VS_START 160, VS_END 166: sync windows, half-open [START, END).
REQ-007 SHALL have parameter FW, default 16: frame counter width.
REQ-008 clk  in  1  single clock for the block.
REQ-009 rst_b  in  1  asynchronous reset, active-low.
REQ-010 enable  in  1  timing runs when 1; freezes when 0.
REQ-011 lyc  in  $clog2(V_TOTAL)  vcount compare value (DISPSTAT[15:8]).
REQ-012 irq_en  in  3  enables: [0] vblank, [1] hblank, [2] vcount match.
REQ-013 hcount  out  $clog2(H_TOTAL)  current dot.
REQ-014 vcount  out  $clog2(V_TOTAL)  current line.
REQ-015 hblank, vblank, hsync, vsync  out  1 each  level flags.
REQ-016 vcount_match  out  1  level, vcount==lyc.
REQ-017 vblank_irq, hblank_irq, vcount_irq  out  1 each  single-cycle request pulses.
REQ-018 dot_tick  out  1  high in the cycle that hcount advances.
REQ-019 frame_count  out  FW  completed-frame counter.

Function
REQ-020 Divider div SHALL count 0..CLK_DIV-1 while enable=1; dot_tick = enable && div==CLK_DIV-1 (combinational on registered div).
REQ-021 On dot_tick, hcount SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and vcount SHALL increment.
REQ-022 When hcount wraps and vcount==V_TOTAL-1, vcount SHALL wrap to 0 and frame_count SHALL increment, modulo 2^FW.
REQ-023 Flags SHALL be registered and updated on the same edge as the counters, so each always reflects the current counts:
- hblank = hcount>=H_ACTIVE
- vblank = vcount>=V_ACTIVE
- hsync = hcount in [HS_START,HS_END)
- vsync = vcount in [VS_START,VS_END)
REQ-024 vcount_match SHALL register (next vcount == current lyc) every cycle, so that a change to lyc takes effect one cycle later, even when enable=0.
REQ-025 hblank_irq SHALL pulse for exactly 1 cycle, coincident with the hblank 0->1 edge, when irq_en[1]=1.
REQ-026 vblank_irq SHALL pulse coincident with the vblank 0->1 edge, when irq_en[0]=1.
REQ-027 vcount_irq SHALL pulse coincident with any vcount_match 0->1 edge, whether caused by a vcount advance or an lyc change, when irq_en[2]=1.
REQ-028 Disabled edges SHALL be lost; enabling later SHALL NOT produce a retroactive pulse.
REQ-029 Simultaneous events SHALL drive their pulses in the same cycle, independently.
- Example: line V_ACTIVE entry gives vblank_irq. With lyc=V_ACTIVE it also gives vcount_irq.
REQ-030 enable=0 SHALL hold div, hcount, vcount, frame_count and flags, and SHALL force dot_tick to 0.
REQ-031 Resuming enable SHALL continue from the held div value; no dot SHALL be skipped or repeated.
REQ-032 Wrap arithmetic SHALL use compares against H_TOTAL-1/V_TOTAL-1 only, with no reliance on power-of-two widths.

Reset
REQ-033 While rst_b=0, all of the following SHALL be 0 asynchronously: div, hcount, vcount, frame_count, all flags, vcount_match, all irq pulses.
REQ-034 After release, counting SHALL start on the first rising clk edge with enable=1.
REQ-035 A reset asserted mid-frame SHALL return every output to its reset value immediately, with no pulse emitted on release.
- Exception: if lyc=0, vcount_match SHALL rise one cycle after release. It pulses vcount_irq when irq_en[2]=1.

Verification (default parameters; edge 1 = first edge after rst_b release, enable=1, irq_en=7, lyc=3)
REQ-036 Edge 4: hcount becomes 1 and dot_tick is high for edge 4 only. Edge 960: hblank rises and hblank_irq is high for 1 cycle. Edge 1232: hcount=0, vcount=1, hblank=0.
REQ-037 Edge 3696: vcount=3, vcount_match=1, vcount_irq pulse. Edge 4928: vcount_match falls with no pulse.
REQ-038 Edge 197120: vblank rises and vblank_irq pulses. Edge 280896: vcount=0, vblank=0, frame_count=1.
REQ-039 At hcount=100, drop enable for 50 cycles: counters and flags hold, dot_tick=0, no pulses. On resume, hblank rises exactly 560 enabled cycles later.
REQ-040 At vcount=10 with irq_en[2]=1, write lyc=10: vcount_match rises next cycle with one vcount_irq pulse. Repeat with irq_en[2]=0: no pulse.
REQ-041 Pulse rst_b low at vcount=150, hcount=200: all outputs 0 within the reset window. After release, the REQ-036 timing repeats exactly.
